// File: rtl/space_pkg.sv
// Shared constants for the game's input side: quadrature states, step directions
// and the screen geometry that bounds the ship's x-coordinate.
package space_pkg;

  typedef enum logic [1:0] {
    QUAD_00 = 2'b00,
    QUAD_01 = 2'b01,
    QUAD_11 = 2'b11,
    QUAD_10 = 2'b10
  } quad_state_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  localparam int SCREEN_W = 640;
  localparam int SHIP_W   = 32;

  // Next {A,B} state when turning clockwise: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] quad_cw_next(input logic [1:0] q);
    case (q)
      QUAD_00: return QUAD_01;
      QUAD_01: return QUAD_11;
      QUAD_11: return QUAD_10;
      default: return QUAD_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One encoder channel: 2-FF synchroniser followed by a glitch filter that only
// follows the synced pin after it has held a new value for FILTER_CYCLES clocks.
module quad_input_filter #(
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic filtered,
  output logic stable
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [1:0]    primed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      cnt      <= '0;
      filtered <= 1'b0;
      primed   <= 2'b00;
    end else begin
      sync1  <= pin;
      sync2  <= sync1;
      primed <= {primed[0], 1'b1};
      if (sync2 != filtered) begin
        if (cnt == CNT_LAST) begin
          filtered <= sync2;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Stable only once the synchroniser holds real pin samples, so the reset
  // zeros in the pipeline are never mistaken for a settled pin level.
  assign stable = primed[1] && (sync2 == filtered);

endmodule

// File: rtl/rotary_position_decoder.sv
// Quadrature reader for one rotary encoder: filters A/B, decodes Gray-code steps
// into detents and keeps a saturating ship x-position.
module rotary_position_decoder
  import space_pkg::*;
#(
  parameter int FILTER_CYCLES = 16,
  parameter int POS_WIDTH     = 10,
  parameter int POS_MIN       = 0,
  parameter int POS_MAX       = SCREEN_W - SHIP_W,
  parameter int POS_RESET     = 304,
  parameter int STEP          = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rota,
  input  logic                 rotb,
  input  logic                 enable,
  input  logic                 pos_load,
  input  logic [POS_WIDTH-1:0] pos_load_value,
  output logic                 step_pulse,
  output logic                 step_dir,
  output logic                 quad_error,
  output logic [POS_WIDTH-1:0] position,
  output logic                 at_min,
  output logic                 at_max
);

  localparam int AW = POS_WIDTH + 2;
  localparam logic signed [AW-1:0] MIN_S  = AW'(POS_MIN);
  localparam logic signed [AW-1:0] MAX_S  = AW'(POS_MAX);
  localparam logic signed [AW-1:0] STEP_S = AW'(STEP);

  function automatic logic [POS_WIDTH-1:0] clamp_pos(input logic signed [AW-1:0] v);
    if (v > MAX_S)      return MAX_S[POS_WIDTH-1:0];
    else if (v < MIN_S) return MIN_S[POS_WIDTH-1:0];
    else                return v[POS_WIDTH-1:0];
  endfunction

  logic filt_a, filt_b, stable_a, stable_b;

  quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_a (
    .clk      (clk),
    .reset    (reset),
    .pin      (rota),
    .filtered (filt_a),
    .stable   (stable_a)
  );

  quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_b (
    .clk      (clk),
    .reset    (reset),
    .pin      (rotb),
    .filtered (filt_b),
    .stable   (stable_b)
  );

  logic [1:0]        cur;
  logic [1:0]        prev_q;
  logic              captured;
  logic signed [2:0] acc;

  logic signed [3:0] acc_sum;
  logic signed [2:0] acc_next;
  logic              step_fire;
  logic              step_cw;
  logic              err_fire;

  assign cur = {filt_a, filt_b};

  // One quarter-step per filtered change; a full detent is four in one direction.
  always_comb begin
    acc_sum   = signed'({acc[2], acc});
    acc_next  = acc;
    step_fire = 1'b0;
    step_cw   = 1'b0;
    err_fire  = 1'b0;
    if (captured && (cur != prev_q)) begin
      if (cur == ~prev_q) begin
        err_fire = 1'b1;
        acc_next = '0;
      end else begin
        if (cur == quad_cw_next(prev_q)) acc_sum = signed'({acc[2], acc}) + 4'sd1;
        else                             acc_sum = signed'({acc[2], acc}) - 4'sd1;
        if ((acc_sum == 4'sd4) || (acc_sum == -4'sd4)) begin
          step_fire = 1'b1;
          step_cw   = (acc_sum == 4'sd4);
          acc_next  = '0;
        end else begin
          acc_next = acc_sum[2:0];
        end
      end
    end
  end

  logic signed [AW-1:0] pos_ext;
  logic signed [AW-1:0] pos_stepped;
  logic signed [AW-1:0] load_ext;

  assign pos_ext     = signed'({2'b00, position});
  assign pos_stepped = step_cw ? (pos_ext + STEP_S) : (pos_ext - STEP_S);
  assign load_ext    = signed'({2'b00, pos_load_value});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      position   <= POS_WIDTH'(POS_RESET);
      step_pulse <= 1'b0;
      step_dir   <= DIR_CCW;
      quad_error <= 1'b0;
      acc        <= '0;
      captured   <= 1'b0;
      prev_q     <= QUAD_00;
    end else begin
      step_pulse <= step_fire;
      quad_error <= err_fire;
      acc        <= acc_next;
      if (step_fire) step_dir <= step_cw ? DIR_CW : DIR_CCW;
      // The first settled pin pair only seeds the reference state.
      if (!captured) begin
        if (stable_a && stable_b) begin
          captured <= 1'b1;
          prev_q   <= cur;
        end
      end else begin
        prev_q <= cur;
      end
      if (pos_load)                 position <= clamp_pos(load_ext);
      else if (step_fire && enable) position <= clamp_pos(pos_stepped);
    end
  end

  assign at_min = (position == POS_WIDTH'(POS_MIN));
  assign at_max = (position == POS_WIDTH'(POS_MAX));

endmodule

// File: tb/tb_rotary_position_decoder.sv
// Directed bench for rotary_position_decoder with FILTER_CYCLES=4: detents,
// glitch rejection, illegal jumps, saturation, enable, load priority, reset.
module tb_rotary_position_decoder;

  logic       clk;
  logic       reset;
  logic       rota;
  logic       rotb;
  logic       enable;
  logic       pos_load;
  logic [9:0] pos_load_value;
  logic       step_pulse;
  logic       step_dir;
  logic       quad_error;
  logic [9:0] position;
  logic       at_min;
  logic       at_max;

  int n_checks = 0;
  int n_pass   = 0;
  int n_step   = 0;
  int n_err    = 0;

  rotary_position_decoder #(.FILTER_CYCLES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .rota           (rota),
    .rotb           (rotb),
    .enable         (enable),
    .pos_load       (pos_load),
    .pos_load_value (pos_load_value),
    .step_pulse     (step_pulse),
    .step_dir       (step_dir),
    .quad_error     (quad_error),
    .position       (position),
    .at_min         (at_min),
    .at_max         (at_max)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (step_pulse) n_step++;
      if (quad_error) n_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input logic a, input logic b);
    rota = a;
    rotb = b;
    tick(10);
  endtask

  task automatic cw_detent();
    set_pins(0, 1); set_pins(1, 1); set_pins(1, 0); set_pins(0, 0);
  endtask

  task automatic ccw_detent();
    set_pins(1, 0); set_pins(1, 1); set_pins(0, 1); set_pins(0, 0);
  endtask

  task automatic load(input logic [9:0] v);
    pos_load_value = v;
    pos_load = 1'b1;
    tick(1);
    pos_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rota = 1'b1; rotb = 1'b1;
    enable = 1'b1; pos_load = 1'b0; pos_load_value = '0;
    tick(3);
    check("rst_position", 32'(position), 304);
    check("rst_step_pulse", 32'(step_pulse), 0);
    check("rst_quad_error", 32'(quad_error), 0);
    check("rst_step_dir", 32'(step_dir), 0);
    reset = 1'b0;
    tick(20);
    check("settle11_steps", n_step, 0);
    check("settle11_errors", n_err, 0);
    check("settle11_position", 32'(position), 304);

    // re-capture from 00 so detents start at the detent rest position
    reset = 1'b1; tick(1);
    rota = 1'b0; rotb = 1'b0; tick(2);
    reset = 1'b0; tick(20);
    check("settle00_errors", n_err, 0);

    set_pins(0, 1); set_pins(1, 1); set_pins(1, 0);
    check("cw_partial_steps", n_step, 0);
    rota = 1'b0;
    tick(6);
    check("cw_latency_early", 32'(step_pulse), 0);
    tick(1);
    check("cw_pulse", 32'(step_pulse), 1);
    check("cw_position", 32'(position), 308);
    tick(3);
    check("cw_pulse_width", 32'(step_pulse), 0);
    check("cw_steps", n_step, 1);
    check("cw_dir", 32'(step_dir), 1);

    ccw_detent();
    check("ccw_steps", n_step, 2);
    check("ccw_dir", 32'(step_dir), 0);
    check("ccw_position", 32'(position), 304);

    // park at 10 with three CW quarters banked, then glitch A low
    set_pins(0, 1); set_pins(1, 1); set_pins(1, 0);
    rota = 1'b0; tick(3); rota = 1'b1; tick(12);
    check("glitch3_steps", n_step, 2);
    check("glitch3_position", 32'(position), 304);
    rota = 1'b0; tick(5); rota = 1'b1; tick(12);
    check("glitch5_steps", n_step, 3);
    check("glitch5_dir", 32'(step_dir), 1);
    check("glitch5_position", 32'(position), 308);
    set_pins(0, 0);
    check("glitch5_return_steps", n_step, 3);

    // two CW quarters banked, then an illegal 11 -> 00 jump
    set_pins(0, 1); set_pins(1, 1);
    set_pins(0, 0);
    check("illegal_errors", n_err, 1);
    check("illegal_steps", n_step, 3);
    check("illegal_position", 32'(position), 308);
    set_pins(0, 1); set_pins(1, 1); set_pins(1, 0);
    check("illegal_acc_cleared", n_step, 3);
    set_pins(0, 0);
    check("after_illegal_steps", n_step, 4);
    check("after_illegal_position", 32'(position), 312);

    load(10'd606);
    check("load_606", 32'(position), 606);
    cw_detent();
    check("sat_hi_position", 32'(position), 608);
    check("sat_hi_at_max", 32'(at_max), 1);
    cw_detent();
    check("sat_hi_hold", 32'(position), 608);
    check("sat_hi_steps", n_step, 6);
    load(10'd700);
    check("load_700_clamped", 32'(position), 608);
    load(10'd2);
    check("load_2", 32'(position), 2);
    ccw_detent();
    check("sat_lo_position", 32'(position), 0);
    check("sat_lo_at_min", 32'(at_min), 1);
    check("sat_lo_at_max", 32'(at_max), 0);

    enable = 1'b0;
    cw_detent();
    enable = 1'b1;
    check("disabled_steps", n_step, 8);
    check("disabled_dir", 32'(step_dir), 1);
    check("disabled_position", 32'(position), 0);

    // load collides with the step of the final quarter
    set_pins(0, 1); set_pins(1, 1); set_pins(1, 0);
    rota = 1'b0;
    tick(6);
    pos_load_value = 10'd100;
    pos_load = 1'b1;
    tick(1);
    pos_load = 1'b0;
    check("collide_pulse", 32'(step_pulse), 1);
    check("collide_position", 32'(position), 100);
    tick(3);
    check("collide_steps", n_step, 9);
    check("collide_hold", 32'(position), 100);

    // reset mid-rotation with two CW quarters banked, pins left at 11
    set_pins(0, 1); set_pins(1, 1);
    reset = 1'b1;
    tick(1);
    check("midrst_position", 32'(position), 304);
    check("midrst_step_pulse", 32'(step_pulse), 0);
    reset = 1'b0;
    tick(20);
    check("midrst_errors", n_err, 1);
    set_pins(1, 0); set_pins(0, 0);
    check("midrst_acc_cleared", n_step, 9);
    set_pins(0, 1); set_pins(1, 1);
    check("midrst_step", n_step, 10);
    check("midrst_final_position", 32'(position), 308);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
